// File: rtl/neuromorphic_xn_macro.sv
// Parametrised ROWS x COLS synaptic-weight crossbar behind a single-request bus, with modelled read/write latency and row-serial MAC.
// Optional scan chain over the weight array is enabled by defining NEUROMORPHIC_XN_SCAN_EN.
module neuromorphic_xn_macro #(
  parameter int ROWS     = 32,
  parameter int COLS     = 32,
  parameter int WEIGHT_W = 4,
  parameter int WR_LAT   = 4,
  parameter int RD_LAT   = 2
) (
  input  logic        CLKin,
  input  logic        RSTin,
  input  logic        EN,
  input  logic        R_WB,
  input  logic [31:0] DI,
  input  logic [31:0] AD,
  input  logic [3:0]  SEL,
`ifdef NEUROMORPHIC_XN_SCAN_EN
  input  logic        TM,
  input  logic        SM,
  input  logic        ScanInCC,
  output logic        ScanOutCC,
`endif
  output logic [31:0] DO,
  output logic        func_ack,
  output logic        busy,
  output logic        err
);

  localparam int         NBITS  = ROWS * COLS * WEIGHT_W;
  localparam logic [8:0] ROWS_L = 9'(ROWS);
  localparam logic [8:0] COLS_L = 9'(COLS);

  typedef enum logic [2:0] {IDLE, READ, WRITE, MAC, ACK} state_e;

  state_e              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [15:0]         ad_q, ad_d;
  logic [31:0]         di_q, di_d;
  logic                sel0_q, sel0_d;
  logic [31:0]         acc_q, acc_d;
  logic [31:0]         do_q, do_d;
  logic                ack_q, ack_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [NBITS-1:0]    mem_q, mem_d;

  logic                scan_shift;
  logic                row_bad, col_bad;
  int                  cell_idx, mac_idx;
  logic [WEIGHT_W-1:0] rd_w, mac_w;
  logic [31:0]         acc_nx;
  logic                unused_bits;

  assign unused_bits = ^{AD[30:16], SEL[3:1]};

`ifdef NEUROMORPHIC_XN_SCAN_EN
  assign scan_shift = TM & SM;
  assign ScanOutCC  = mem_q[0];
`else
  assign scan_shift = 1'b0;
`endif

  assign row_bad  = {1'b0, AD[15:8]} >= ROWS_L;
  assign col_bad  = {1'b0, AD[7:0]} >= COLS_L;
  assign cell_idx = int'(ad_q[15:8]) * COLS + int'(ad_q[7:0]);
  assign mac_idx  = int'(cnt_q) * COLS + int'(ad_q[7:0]);
  assign rd_w     = mem_q[cell_idx*WEIGHT_W +: WEIGHT_W];
  assign mac_w    = mem_q[mac_idx*WEIGHT_W +: WEIGHT_W];
  assign acc_nx   = acc_q + (di_q[cnt_q[4:0]] ? 32'(mac_w) : 32'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ad_d    = ad_q;
    di_d    = di_q;
    sel0_d  = sel0_q;
    acc_d   = acc_q;
    do_d    = do_q;
    ack_d   = 1'b0;
    busy_d  = busy_q;
    err_d   = 1'b0;
    mem_d   = mem_q;
    unique case (state_q)
      IDLE: begin
        if (EN) begin
          ad_d   = AD[15:0];
          di_d   = DI;
          sel0_d = SEL[0];
          cnt_d  = '0;
          acc_d  = '0;
          busy_d = 1'b1;
          // MAC only checks the column; the row field is a don't-care there
          if ((R_WB && AD[31]) ? col_bad : (row_bad || col_bad)) begin
            state_d = ACK;
            ack_d   = 1'b1;
            err_d   = 1'b1;
            do_d    = '0;
          end else if (R_WB) begin
            state_d = AD[31] ? MAC : READ;
          end else begin
            state_d = WRITE;
          end
        end
      end
      READ: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(RD_LAT - 1)) begin
          state_d = ACK;
          ack_d   = 1'b1;
          do_d    = 32'(rd_w);
        end
      end
      WRITE: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(WR_LAT - 1)) begin
          if (sel0_q) mem_d[cell_idx*WEIGHT_W +: WEIGHT_W] = di_q[WEIGHT_W-1:0];
          state_d = ACK;
          ack_d   = 1'b1;
        end
      end
      MAC: begin
        cnt_d = cnt_q + 16'd1;
        acc_d = acc_nx;
        if (cnt_q == 16'(ROWS - 1)) begin
          state_d = ACK;
          ack_d   = 1'b1;
          do_d    = acc_nx;
        end
      end
      ACK: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // Scan shifting owns the array and silently aborts any request
    if (scan_shift) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      mem_d   = mem_q;
`ifdef NEUROMORPHIC_XN_SCAN_EN
      mem_d   = {ScanInCC, mem_q[NBITS-1:1]};
`endif
    end
  end

  always_ff @(posedge CLKin or negedge RSTin) begin
    if (!RSTin) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ad_q    <= '0;
      di_q    <= '0;
      sel0_q  <= 1'b0;
      acc_q   <= '0;
      do_q    <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ad_q    <= ad_d;
      di_q    <= di_d;
      sel0_q  <= sel0_d;
      acc_q   <= acc_d;
      do_q    <= do_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  end

  assign DO       = do_q;
  assign func_ack = ack_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_neuromorphic_xn_macro.sv
// Randomised self-checking bench for neuromorphic_xn_macro against an array-based reference model.
module tb_neuromorphic_xn_macro;
  localparam int ROWS = 32, COLS = 32, WEIGHT_W = 4, WR_LAT = 4, RD_LAT = 2;
  localparam int NB   = ROWS * COLS * WEIGHT_W;

  logic        CLKin = 1'b0, RSTin = 1'b0, EN = 1'b0, R_WB = 1'b0;
  logic [31:0] DI = '0, AD = '0;
  logic [3:0]  SEL = '0;
  logic [31:0] DO;
  logic        func_ack, busy, err;
`ifdef NEUROMORPHIC_XN_SCAN_EN
  logic TM = 1'b0, SM = 1'b0, ScanInCC = 1'b0;
  logic ScanOutCC;
`endif

  neuromorphic_xn_macro #(.ROWS(ROWS), .COLS(COLS), .WEIGHT_W(WEIGHT_W),
                          .WR_LAT(WR_LAT), .RD_LAT(RD_LAT)) dut (
    .CLKin(CLKin), .RSTin(RSTin), .EN(EN), .R_WB(R_WB), .DI(DI), .AD(AD), .SEL(SEL),
`ifdef NEUROMORPHIC_XN_SCAN_EN
    .TM(TM), .SM(SM), .ScanInCC(ScanInCC), .ScanOutCC(ScanOutCC),
`endif
    .DO(DO), .func_ack(func_ack), .busy(busy), .err(err));

  always #5 CLKin = ~CLKin;

  int          n_checks = 0, n_errors = 0;
  int          model [ROWS][COLS];
  logic [31:0] exp_do = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) model[r][c] = 0;
    exp_do = '0;
  endtask

  // Issue one request from IDLE; returns ack latency (cycles after accept edge), DO and err at the ack.
  task automatic run_op(input logic rwb, input logic [31:0] ad, input logic [31:0] di,
                        input logic [3:0] sel, input bit poke_en,
                        output int lat, output logic [31:0] dout, output logic e);
    bit busy_all;
    @(negedge CLKin);
    check_eq("idle_busy", {31'b0, busy}, 32'd0);
    EN = 1'b1; R_WB = rwb; AD = ad; DI = di; SEL = sel;
    @(negedge CLKin);
    EN = 1'b0; AD = $urandom(); DI = $urandom(); SEL = 4'($urandom());
    lat = -1; busy_all = 1'b1; dout = '0; e = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (k > 1) @(negedge CLKin);
      if (!busy) busy_all = 1'b0;
      if (func_ack) begin
        lat = k; dout = DO; e = err;
        break;
      end
      if (poke_en) EN = ~EN;
    end
    EN = 1'b0;
    if (lat < 0) check_eq("ack_timeout", 32'd0, 32'd1);
    check_eq("busy_during_op", {31'b0, busy_all}, 32'd1);
  endtask

  task automatic do_read(input int row, input int col, output logic [31:0] dout);
    int lat; logic e; bit bad; logic [31:0] expv;
    bad  = (row >= ROWS) || (col >= COLS);
    expv = bad ? 32'd0 : 32'(model[row][col]);
    run_op(1'b1, {1'b0, 15'($urandom()), 8'(row), 8'(col)}, $urandom(), 4'($urandom()), 1'b0, lat, dout, e);
    check_eq("rd_lat", lat, bad ? 1 : RD_LAT + 1);
    check_eq("rd_do", dout, expv);
    check_eq("rd_err", {31'b0, e}, {31'b0, bad});
    exp_do = expv;
  endtask

  task automatic do_write(input int row, input int col, input logic [31:0] di,
                          input logic [3:0] sel, input bit poke_en);
    int lat; logic e; bit bad; logic [31:0] dout;
    bad = (row >= ROWS) || (col >= COLS);
    run_op(1'b0, {1'b0, 15'($urandom()), 8'(row), 8'(col)}, di, sel, poke_en, lat, dout, e);
    if (bad) exp_do = '0;
    else if (sel[0]) model[row][col] = int'(di) & ((1 << WEIGHT_W) - 1);
    check_eq("wr_lat", lat, bad ? 1 : WR_LAT + 1);
    check_eq("wr_do", dout, exp_do);
    check_eq("wr_err", {31'b0, e}, {31'b0, bad});
  endtask

  task automatic do_mac(input logic [31:0] ad, input logic [31:0] di, output logic [31:0] dout);
    int lat; logic e; bit bad; int col, sum;
    col = int'(ad[7:0]);
    bad = col >= COLS;
    sum = 0;
    if (!bad)
      for (int r = 0; r < ROWS; r++) if (di[r]) sum += model[r][col];
    run_op(1'b1, ad, di, 4'($urandom()), 1'b0, lat, dout, e);
    check_eq("mac_lat", lat, bad ? 1 : ROWS + 1);
    check_eq("mac_do", dout, bad ? 32'd0 : 32'(sum));
    check_eq("mac_err", {31'b0, e}, {31'b0, bad});
    exp_do = bad ? 32'd0 : 32'(sum);
  endtask

  initial begin
    logic [31:0] d;
    int extra;
    clear_model();
    // Reset with EN toggling
    repeat (4) begin
      @(negedge CLKin);
      EN = ~EN; R_WB = 1'b1;
      check_eq("rst_do", DO, 32'd0);
      check_eq("rst_ack", {31'b0, func_ack}, 32'd0);
      check_eq("rst_busy", {31'b0, busy}, 32'd0);
      check_eq("rst_err", {31'b0, err}, 32'd0);
    end
    @(negedge CLKin);
    EN = 1'b0; RSTin = 1'b1;
    do_read(3, 5, d);
    check_eq("rst_read_val", d, 32'd0);

    // Write/read and SEL[0] masking
    do_write(3, 5, 32'h0000_000B, 4'h1, 1'b0);
    do_read(3, 5, d);
    check_eq("wr_rd_val", d, 32'h0000_000B);
    do_write(3, 5, 32'h0000_0002, 4'h0, 1'b0);
    do_read(3, 5, d);
    check_eq("sel0_masked", d, 32'h0000_000B);

    // Directed MAC on column 7
    do_write(0, 7, 32'd1, 4'h1, 1'b0);
    do_write(1, 7, 32'd2, 4'h1, 1'b0);
    do_write(2, 7, 32'd3, 4'h1, 1'b0);
    do_write(31, 7, 32'd15, 4'h1, 1'b0);
    do_mac(32'h8000_0007, 32'h8000_0005, d);
    check_eq("mac_directed", d, 32'd19);

    // Range errors
    do_read(33, 0, d);
    do_read(0, 40, d);
    do_write(40, 1, 32'h5, 4'h1, 1'b0);
    do_mac(32'h8000_0028, 32'hFFFF_FFFF, d);
    do_mac(32'h8000_FF07, 32'h0000_0002, d);

    // EN pulses during a write are ignored: exactly one ack
    do_write(4, 4, 32'h6, 4'h1, 1'b1);
    extra = 0;
    repeat (6) begin
      @(negedge CLKin);
      if (func_ack) extra++;
    end
    check_eq("no_extra_ack", extra, 32'd0);

    // Reset during a write aborts it and clears all weights
    @(negedge CLKin);
    EN = 1'b1; R_WB = 1'b0; AD = {16'h0, 8'd1, 8'd2}; DI = 32'h7; SEL = 4'h1;
    @(negedge CLKin);
    EN = 1'b0;
    @(negedge CLKin);
    RSTin = 1'b0;
    clear_model();
    @(negedge CLKin);
    check_eq("abort_busy", {31'b0, busy}, 32'd0);
    RSTin = 1'b1;
    repeat (WR_LAT + 2) @(negedge CLKin);
    do_read(1, 2, d);
    check_eq("abort_cell", d, 32'd0);
    do_read(4, 4, d);

    // Randomised traffic
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 2))
        0: do_read(int'($urandom_range(0, 35)), int'($urandom_range(0, 35)), d);
        1: do_write(int'($urandom_range(0, 35)), int'($urandom_range(0, 35)), $urandom(),
                    4'($urandom()), 1'b0);
        default: do_mac({1'b1, 15'($urandom()), 8'($urandom()), 8'($urandom_range(0, 35))},
                        $urandom(), d);
      endcase
    end

`ifdef NEUROMORPHIC_XN_SCAN_EN
    begin
      bit stream [NB];
      int mism;
      @(negedge CLKin);
      TM = 1'b1; SM = 1'b1;
      for (int i = 0; i < NB; i++) begin
        stream[i] = (i < 4) ? ((4'h9 >> i) & 4'h1) != 0 : 1'($urandom());
        ScanInCC = stream[i];
        @(negedge CLKin);
      end
      SM = 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          model[r][c] = 0;
          for (int b = 0; b < WEIGHT_W; b++)
            if (stream[(r * COLS + c) * WEIGHT_W + b]) model[r][c] += (1 << b);
        end
      do_read(0, 0, d);
      check_eq("scan_cell00", d, 32'd9);
      do_read(17, 9, d);
      @(negedge CLKin);
      SM = 1'b1;
      mism = 0;
      for (int i = 0; i < NB; i++) begin
        if (ScanOutCC !== stream[i]) mism++;
        ScanInCC = 1'b0;
        @(negedge CLKin);
      end
      check_eq("scan_out_stream", mism, 32'd0);
      SM = 1'b0; TM = 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) model[r][c] = 0;
      do_read(0, 0, d);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
